descrambler_bypass_ctrl: RTL and testbench

//  Per-lane descrambler bypass controller for the PCIe MAC receive path, Gen1-Gen5.

---
 rtl/descrambler_bypass_ctrl.sv | 91 +++++++++
 tb/tb_descrambler_bypass_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/descrambler_bypass_ctrl.sv
// descrambler_bypass_ctrl: per-lane descrambler bypass, LFSR hold and seed-load control
// Each lane runs an IDLE/BUSY FSM timed by a down-counter loaded with the OS length in PIPE cycles.
module descrambler_bypass_ctrl #(
  parameter int NUM_LANES = 16,
  parameter int CNT_W     = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             gen,
  input  logic [5:0]             pipe_width,
  input  logic [NUM_LANES-1:0]   os_start,
  input  logic [2*NUM_LANES-1:0] os_type,
  output logic [NUM_LANES-1:0]   bypass,
  output logic [NUM_LANES-1:0]   lfsr_hold,
  output logic [NUM_LANES-1:0]   seed_load,
  output logic [NUM_LANES-1:0]   os_overlap,
  output logic                   cfg_err
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t               state_q [NUM_LANES];
  state_t               state_d [NUM_LANES];
  logic [CNT_W-1:0]     cnt_q   [NUM_LANES];
  logic [CNT_W-1:0]     cnt_d   [NUM_LANES];
  logic [NUM_LANES-1:0] g12_q, g12_d, skp_q, skp_d, eie_q, eie_d;
  logic [NUM_LANES-1:0] first_q, first_d, ovl_q, ovl_d;
  logic                 cfg_err_q, cfg_err_d;
  logic                 gen_ok, width_ok, g12_in;
  logic [1:0]           sh;
  always_comb begin
    gen_ok    = (gen != 3'd0) && (gen < 3'd6);
    width_ok  = (pipe_width == 6'd8) || (pipe_width == 6'd16) || (pipe_width == 6'd32);
    g12_in    = (gen == 3'd1) || (gen == 3'd2);
    sh        = (pipe_width == 6'd16) ? 2'd1 : (pipe_width == 6'd32) ? 2'd2 : 2'd0;
    cfg_err_d = !gen_ok || !width_ok;
  end
  // A busy lane may only accept a new OS on its final count cycle (back-to-back).
  always_comb begin
    logic             run;
    logic             start;
    logic [1:0]       ty;
    logic [CNT_W-1:0] len;
    for (int i = 0; i < NUM_LANES; i++) begin
      ty         = os_type[2*i +: 2];
      run        = (state_q[i] == BUSY) && (cnt_q[i] != '0);
      start      = os_start[i] && gen_ok && !run;
      len        = (g12_in && ty == 2'd1) ? CNT_W'(4) : CNT_W'(16);
      state_d[i] = (start || run) ? BUSY : IDLE;
      cnt_d[i]   = start ? (len >> sh) - CNT_W'(1) : run ? cnt_q[i] - CNT_W'(1) : '0;
      g12_d[i]   = start ? g12_in : g12_q[i];
      skp_d[i]   = start ? (ty == 2'd1) : skp_q[i];
      eie_d[i]   = start ? (ty == 2'd2) : eie_q[i];
      first_d[i] = start;
      ovl_d[i]   = os_start[i] && run;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      g12_q     <= '0;
      skp_q     <= '0;
      eie_q     <= '0;
      first_q   <= '0;
      ovl_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      g12_q     <= g12_d;
      skp_q     <= skp_d;
      eie_q     <= eie_d;
      first_q   <= first_d;
      ovl_q     <= ovl_d;
      cfg_err_q <= cfg_err_d;
    end
  end
  // Gen1/2 reseeds at the COM of every OS; Gen3+ reseeds only as an EIEOS finishes.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      bypass[i]     = (state_q[i] == BUSY);
      lfsr_hold[i]  = (state_q[i] == BUSY) && g12_q[i] && skp_q[i];
      seed_load[i]  = (state_q[i] == BUSY) && (g12_q[i] ? first_q[i] : (eie_q[i] && cnt_q[i] == '0));
      os_overlap[i] = ovl_q[i];
    end
    cfg_err = cfg_err_q;
  end
endmodule

// File: tb/tb_descrambler_bypass_ctrl.sv
// tb_descrambler_bypass_ctrl: directed and random checks against a timeline reference model
// The model schedules expected outputs per absolute cycle when an OS is accepted.
module tb_descrambler_bypass_ctrl;
  logic        clk = 0;
  logic        reset = 0;
  logic [2:0]  gen = 3'd2;
  logic [5:0]  pipe_width = 6'd8;
  logic [15:0] os_start = '0;
  logic [31:0] os_type = '0;
  logic [15:0] bypass, lfsr_hold, seed_load, os_overlap;
  logic        cfg_err;
  int          c = 0, errors = 0, checks = 0;
  bit   [15:0] eb [2048];
  bit   [15:0] eh [2048];
  bit   [15:0] es [2048];
  bit   [15:0] eo [2048];
  bit          ec [2048];
  int          busy_until [16];
  bit          in_rst = 1;

  descrambler_bypass_ctrl dut (.clk(clk), .reset(reset), .gen(gen), .pipe_width(pipe_width),
    .os_start(os_start), .os_type(os_type), .bypass(bypass), .lfsr_hold(lfsr_hold),
    .seed_load(seed_load), .os_overlap(os_overlap), .cfg_err(cfg_err));

  always #5 clk = ~clk;

  function automatic int olen(int g, int w, int ty);
    int l = (g <= 2 && ty == 1) ? 4 : 16;
    int b = (w == 16) ? 2 : (w == 32) ? 4 : 1;
    return (l / b < 1) ? 1 : l / b;
  endfunction

  task automatic model_clear();
    for (int t = c; t < 2048; t++) begin
      eb[t] = '0; eh[t] = '0; es[t] = '0; eo[t] = '0; ec[t] = 0;
    end
    for (int l = 0; l < 16; l++) busy_until[l] = -1;
  endtask

  task automatic tick();
    int ty, n;
    bit g12;
    if (!in_rst) begin
      ec[c+1] = !(gen >= 1 && gen <= 5) || !(pipe_width == 8 || pipe_width == 16 || pipe_width == 32);
      for (int l = 0; l < 16; l++) if (os_start[l]) begin
        if (busy_until[l] > c) eo[c+1][l] = 1;
        else if (gen >= 1 && gen <= 5) begin
          ty  = int'(os_type[2*l +: 2]);
          g12 = gen <= 2;
          n   = olen(int'(gen), int'(pipe_width), ty);
          for (int t = 1; t <= n; t++) begin
            eb[c+t][l] = 1;
            if (g12 && ty == 1) eh[c+t][l] = 1;
            if (g12 ? t == 1 : (ty == 2 && t == n)) es[c+t][l] = 1;
          end
          busy_until[l] = c + n;
        end
      end
    end
    @(posedge clk);
    c++;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bypass, lfsr_hold, seed_load, os_overlap, cfg_err} !== 65'd0) begin
        errors++; $display("FAIL reset_hold cyc=%0d got=%h exp=0", c, {bypass, lfsr_hold, seed_load, os_overlap, cfg_err});
      end
    end
    reset = 1; in_rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bypass, lfsr_hold, seed_load, os_overlap, cfg_err} !== {eb[c], eh[c], es[c], eo[c], ec[c]}) begin
        errors++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", c, {bypass, lfsr_hold, seed_load, os_overlap, cfg_err}, {eb[c], eh[c], es[c], eo[c], ec[c]});
      end
    end
  endtask

  task automatic test_gen2_ts();
    int nb = 0, ns = 0;
    gen = 2; pipe_width = 8; os_type = '0; os_start = 16'h0001;
    for (int i = 0; i < 20; i++) begin
      tick();
      os_start = '0;
      nb += int'(bypass[0]); ns += int'(seed_load[0] && i == 0);
      checks++;
      if ({bypass, lfsr_hold, seed_load, os_overlap, cfg_err} !== {eb[c], eh[c], es[c], eo[c], ec[c]}) begin
        errors++; $display("FAIL gen2_ts cyc=%0d got=%h exp=%h", c, {bypass, lfsr_hold, seed_load, os_overlap, cfg_err}, {eb[c], eh[c], es[c], eo[c], ec[c]});
      end
    end
    checks++;
    if (nb !== 16 || ns !== 1) begin
      errors++; $display("FAIL gen2_ts_len bypass=%0d seed_first=%0d exp 16/1", nb, ns);
    end
  endtask

  task automatic test_skp();
    int nb, nh;
    for (int w = 0; w < 2; w++) begin
      nb = 0; nh = 0;
      gen = 1; pipe_width = (w == 0) ? 6'd16 : 6'd32; os_type = 32'h1 << 10; os_start = 16'h0020;
      for (int i = 0; i < 6; i++) begin
        tick();
        os_start = '0;
        nb += int'(bypass[5]); nh += int'(lfsr_hold[5]);
        checks++;
        if ({bypass, lfsr_hold, seed_load, os_overlap, cfg_err} !== {eb[c], eh[c], es[c], eo[c], ec[c]}) begin
          errors++; $display("FAIL skp cyc=%0d got=%h exp=%h", c, {bypass, lfsr_hold, seed_load, os_overlap, cfg_err}, {eb[c], eh[c], es[c], eo[c], ec[c]});
        end
      end
      checks++;
      if (nb !== 2 - w || nh !== 2 - w) begin
        errors++; $display("FAIL skp_len width=%0d bypass=%0d hold=%0d exp %0d", pipe_width, nb, nh, 2 - w);
      end
    end
  endtask

  task automatic test_eieos_gen4();
    int nb = 0, seed_at = -1;
    gen = 4; pipe_width = 32; os_type = 32'h2 << 4; os_start = 16'h0004;
    for (int i = 0; i < 8; i++) begin
      tick();
      os_start = '0;
      nb += int'(bypass[2]);
      if (seed_load[2]) seed_at = i;
      checks++;
      if ({bypass, lfsr_hold, seed_load, os_overlap, cfg_err} !== {eb[c], eh[c], es[c], eo[c], ec[c]}) begin
        errors++; $display("FAIL eieos cyc=%0d got=%h exp=%h", c, {bypass, lfsr_hold, seed_load, os_overlap, cfg_err}, {eb[c], eh[c], es[c], eo[c], ec[c]});
      end
    end
    checks++;
    if (nb !== 4 || seed_at !== 3) begin
      errors++; $display("FAIL eieos_len bypass=%0d seed_at=%0d exp 4/3", nb, seed_at);
    end
  endtask

  task automatic test_back_to_back();
    int nb = 0, no = 0, gap = 0;
    gen = 3; pipe_width = 32; os_type = '0;
    for (int i = 0; i < 12; i++) begin
      os_start = (i == 0 || i == 4 || i == 6) ? 16'h0001 : 16'h0000;
      tick();
      nb += int'(bypass[0]); no += int'(os_overlap[0]);
      if (i < 8 && !bypass[0]) gap++;
      checks++;
      if ({bypass, lfsr_hold, seed_load, os_overlap, cfg_err} !== {eb[c], eh[c], es[c], eo[c], ec[c]}) begin
        errors++; $display("FAIL b2b cyc=%0d got=%h exp=%h", c, {bypass, lfsr_hold, seed_load, os_overlap, cfg_err}, {eb[c], eh[c], es[c], eo[c], ec[c]});
      end
    end
    os_start = '0;
    checks++;
    if (nb !== 8 || no !== 1 || gap !== 0) begin
      errors++; $display("FAIL b2b_len bypass=%0d overlap=%0d gaps=%0d exp 8/1/0", nb, no, gap);
    end
  endtask

  task automatic test_lanes_gen_change();
    int n0 = 0, n3 = 0, h3 = 0;
    gen = 1; pipe_width = 8; os_type = 32'h1 << 6; os_start = 16'h0009;
    for (int i = 0; i < 20; i++) begin
      tick();
      os_start = '0;
      if (i == 1) gen = 4;
      n0 += int'(bypass[0]); n3 += int'(bypass[3]); h3 += int'(lfsr_hold[3]);
      checks++;
      if ({bypass, lfsr_hold, seed_load, os_overlap, cfg_err} !== {eb[c], eh[c], es[c], eo[c], ec[c]}) begin
        errors++; $display("FAIL lanes cyc=%0d got=%h exp=%h", c, {bypass, lfsr_hold, seed_load, os_overlap, cfg_err}, {eb[c], eh[c], es[c], eo[c], ec[c]});
      end
    end
    checks++;
    if (n0 !== 16 || n3 !== 4 || h3 !== 4) begin
      errors++; $display("FAIL lanes_len l0=%0d l3=%0d hold3=%0d exp 16/4/4", n0, n3, h3);
    end
  endtask

  task automatic test_mid_reset();
    int nb = 0;
    gen = 2; pipe_width = 8; os_type = '0; os_start = 16'h0002;
    for (int i = 0; i < 3; i++) begin
      tick();
      os_start = '0;
    end
    #2 reset = 0;
    #1;
    checks++;
    if ({bypass, lfsr_hold, seed_load, os_overlap, cfg_err} !== 65'd0) begin
      errors++; $display("FAIL async_reset got=%h exp=0", {bypass, lfsr_hold, seed_load, os_overlap, cfg_err});
    end
    model_clear(); in_rst = 1;
    tick();
    reset = 1; in_rst = 0; os_start = 16'h0002;
    for (int i = 0; i < 18; i++) begin
      tick();
      os_start = '0;
      nb += int'(bypass[1]);
      checks++;
      if ({bypass, lfsr_hold, seed_load, os_overlap, cfg_err} !== {eb[c], eh[c], es[c], eo[c], ec[c]}) begin
        errors++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", c, {bypass, lfsr_hold, seed_load, os_overlap, cfg_err}, {eb[c], eh[c], es[c], eo[c], ec[c]});
      end
    end
    checks++;
    if (nb !== 16) begin
      errors++; $display("FAIL post_reset_len bypass=%0d exp 16", nb);
    end
  endtask

  task automatic test_bad_cfg();
    int nb = 0, ne = 0, n0 = 0;
    gen = 2; pipe_width = 12; os_type = '0; os_start = 16'h0080;
    for (int i = 0; i < 24; i++) begin
      tick();
      os_start = (i == 3) ? 16'h0001 : 16'h0000;
      gen = (i >= 3 && i < 6) ? 3'd6 : 3'd2;
      nb += int'(bypass[7]); ne += int'(cfg_err); n0 += int'(bypass[0]);
      checks++;
      if ({bypass, lfsr_hold, seed_load, os_overlap, cfg_err} !== {eb[c], eh[c], es[c], eo[c], ec[c]}) begin
        errors++; $display("FAIL bad_cfg cyc=%0d got=%h exp=%h", c, {bypass, lfsr_hold, seed_load, os_overlap, cfg_err}, {eb[c], eh[c], es[c], eo[c], ec[c]});
      end
    end
    checks++;
    if (nb !== 16 || ne !== 24 || n0 !== 0) begin
      errors++; $display("FAIL bad_cfg_len bypass=%0d cfg_err_cycles=%0d l0=%0d exp 16/24/0", nb, ne, n0);
    end
    pipe_width = 8;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      gen = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(1, 5)) : 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0: pipe_width = 6'd12;
        1, 2, 3: pipe_width = 6'd8;
        4, 5, 6: pipe_width = 6'd16;
        default: pipe_width = 6'd32;
      endcase
      os_type = $urandom;
      for (int l = 0; l < 16; l++) os_start[l] = ($urandom_range(0, 5) == 0);
      tick();
      checks++;
      if ({bypass, lfsr_hold, seed_load, os_overlap, cfg_err} !== {eb[c], eh[c], es[c], eo[c], ec[c]}) begin
        errors++; $display("FAIL random cyc=%0d got=%h exp=%h", c, {bypass, lfsr_hold, seed_load, os_overlap, cfg_err}, {eb[c], eh[c], es[c], eo[c], ec[c]});
      end
    end
    os_start = '0;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_gen2_ts();
    test_skp();
    test_eieos_gen4();
    test_back_to_back();
    test_lanes_gen_change();
    test_mid_reset();
    test_bad_cfg();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
